// File: rtl/vga_pkg.sv
// Shared VGA constants and the write-scheduler state encoding.
// Also holds the blanking-window decode used by the arbiter.
package vga_pkg;

    localparam int unsigned HD_DEFAULT = 640;
    localparam int unsigned VD_DEFAULT = 480;
    localparam int unsigned PX_W       = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PEND = 2'd1,
        ACK  = 2'd2
    } wr_state_t;

    function automatic logic in_window(
        input logic [PX_W-1:0] x,
        input logic [PX_W-1:0] y,
        input logic [PX_W-1:0] hd,
        input logic [PX_W-1:0] vd,
        input logic            vblank_only
    );
        if (vblank_only)
            return (y >= vd);
        else
            return (x >= hd) || (y >= vd);
    endfunction

endpackage

// File: rtl/vga_regfile.sv
// Single-port display register file: synchronous write, registered read,
// every word cleared asynchronously on rst.
module vga_regfile #(
    parameter int unsigned AW = 4,
    parameter int unsigned DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data,
    output logic          rd_valid,
    input  logic          we,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data
);

    localparam int unsigned DEPTH = 1 << AW;

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++)
                mem[i] <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            if (we)
                mem[wr_addr] <= wr_data;
            if (rd_en)
                rd_data <= mem[rd_addr];
            rd_valid <= rd_en;
        end
    end

endmodule

// File: rtl/vga_mem_arbiter.sv
// Arbitrates the display register file between the pixel renderer (reads,
// absolute priority) and the RTC controller (4-phase writes gated to blanking).
module vga_mem_arbiter #(
    parameter int unsigned AW          = 4,
    parameter int unsigned DW          = 8,
    parameter int unsigned HD          = vga_pkg::HD_DEFAULT,
    parameter int unsigned VD          = vga_pkg::VD_DEFAULT,
    parameter int unsigned VBLANK_ONLY = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [9:0]    px_X,
    input  logic [9:0]    px_Y,
    input  logic          rd_req,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data,
    output logic          rd_valid,
    input  logic          wr_req,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    output logic          wr_ack,
    output logic          wr_busy,
    output logic          vblank_start
);

    import vga_pkg::*;

    localparam logic [9:0] HD_L = 10'(HD);
    localparam logic [9:0] VD_L = 10'(VD);

    wr_state_t     state_q;
    wr_state_t     state_d;
    logic          win;
    logic          commit;
    logic [AW-1:0] wr_addr_q;
    logic [DW-1:0] wr_data_q;
    logic [9:0]    py_d;

    assign win = in_window(px_X, px_Y, HD_L, VD_L, VBLANK_ONLY != 0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (wr_req)          state_d = PEND;
            PEND:    if (win && !rd_req)  state_d = ACK;
            ACK:     if (!wr_req)         state_d = IDLE;
            default:                      state_d = IDLE;
        endcase
    end

    // A read in the same cycle always wins; the commit simply retries later.
    always_comb begin
        wr_busy = 1'b0;
        wr_ack  = 1'b0;
        commit  = 1'b0;
        case (state_q)
            PEND: begin
                wr_busy = 1'b1;
                commit  = win && !rd_req;
            end
            ACK:     wr_ack = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else if (state_q == IDLE && wr_req) begin
            wr_addr_q <= wr_addr;
            wr_data_q <= wr_data;
        end
    end

    // px_Y sits at VD for a whole line, so only the first cycle there pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            py_d         <= '0;
            vblank_start <= 1'b0;
        end else begin
            py_d         <= px_Y;
            vblank_start <= (px_Y == VD_L) && (py_d != VD_L);
        end
    end

    vga_regfile #(
        .AW (AW),
        .DW (DW)
    ) u_regfile (
        .clk      (clk),
        .rst      (rst),
        .rd_en    (rd_req),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .we       (commit),
        .wr_addr  (wr_addr_q),
        .wr_data  (wr_data_q)
    );

endmodule

// File: tb/tb_vga_mem_arbiter.sv
// Scenario bench for vga_mem_arbiter; read results are checked against a
// queue of expected data pushed when each read is issued.
module tb_vga_mem_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [9:0] px_X = '0;
    logic [9:0] px_Y = '0;

    logic       rd_req = 1'b0;
    logic [3:0] rd_addr = '0;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       wr_req = 1'b0;
    logic [3:0] wr_addr = '0;
    logic [7:0] wr_data = '0;
    logic       wr_ack;
    logic       wr_busy;
    logic       vblank_start;

    logic       rd_req_h = 1'b0;
    logic [3:0] rd_addr_h = '0;
    logic [7:0] rd_data_h;
    logic       rd_valid_h;
    logic       wr_req_h = 1'b0;
    logic [3:0] wr_addr_h = '0;
    logic [7:0] wr_data_h = '0;
    logic       wr_ack_h;
    logic       wr_busy_h;
    logic       vblank_start_h;

    int checks = 0;
    int passes = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    vga_mem_arbiter #(
        .AW (4), .DW (8), .HD (640), .VD (480), .VBLANK_ONLY (1)
    ) dut (
        .clk (clk), .rst (rst), .px_X (px_X), .px_Y (px_Y),
        .rd_req (rd_req), .rd_addr (rd_addr), .rd_data (rd_data), .rd_valid (rd_valid),
        .wr_req (wr_req), .wr_addr (wr_addr), .wr_data (wr_data),
        .wr_ack (wr_ack), .wr_busy (wr_busy), .vblank_start (vblank_start)
    );

    vga_mem_arbiter #(
        .AW (4), .DW (8), .HD (640), .VD (480), .VBLANK_ONLY (0)
    ) dut_h (
        .clk (clk), .rst (rst), .px_X (px_X), .px_Y (px_Y),
        .rd_req (rd_req_h), .rd_addr (rd_addr_h), .rd_data (rd_data_h), .rd_valid (rd_valid_h),
        .wr_req (wr_req_h), .wr_addr (wr_addr_h), .wr_data (wr_data_h),
        .wr_ack (wr_ack_h), .wr_busy (wr_busy_h), .vblank_start (vblank_start_h)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        px_X = 10'd100;
        px_Y = 10'd100;
        rst  = 1'b1;
        tick();
        checks++;
        if ({rd_valid, rd_data, wr_ack, wr_busy, vblank_start} !== 12'h000)
            $display("FAIL reset_outputs: got valid=%b data=%h ack=%b busy=%b vbs=%b, want all 0",
                     rd_valid, rd_data, wr_ack, wr_busy, vblank_start);
        else passes++;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_write();
        px_Y    = 10'd100;
        wr_req  = 1'b1;
        wr_addr = 4'd3;
        wr_data = 8'h5A;
        tick();
        checks++;
        if (wr_busy !== 1'b1) $display("FAIL rmw_pend: wr_busy=%b want 1", wr_busy);
        else passes++;
        tick();
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({wr_busy, wr_ack} !== 2'b00)
            $display("FAIL rmw_rst: busy=%b ack=%b want 0 0", wr_busy, wr_ack);
        else passes++;
        wr_req = 1'b0;
        tick();
        rst  = 1'b0;
        px_Y = 10'd480;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (wr_ack !== 1'b0) $display("FAIL rmw_no_ack: wr_ack=%b want 0 (cycle %0d)", wr_ack, i);
            else passes++;
        end
        rd_req  = 1'b1;
        rd_addr = 4'd3;
        exp_q.push_back(8'h00);
        tick();
        rd_req = 1'b0;
        tick();
    endtask

    task automatic test_blank_gate();
        px_Y    = 10'd100;
        wr_req  = 1'b1;
        wr_addr = 4'd2;
        wr_data = 8'h37;
        tick();
        for (int i = 0; i < 4; i++) begin
            rd_req  = (i == 1);
            rd_addr = 4'd2;
            if (i == 1) exp_q.push_back(8'h00);
            tick();
            checks++;
            if ({wr_busy, wr_ack} !== 2'b10)
                $display("FAIL gate_hold: busy=%b ack=%b want 1 0 (cycle %0d)", wr_busy, wr_ack, i);
            else passes++;
        end
        rd_req = 1'b0;
        px_Y   = 10'd480;
        tick();
        checks++;
        if ({wr_busy, wr_ack} !== 2'b01)
            $display("FAIL gate_commit: busy=%b ack=%b want 0 1", wr_busy, wr_ack);
        else passes++;
        wr_req = 1'b0;
        tick();
        checks++;
        if (wr_ack !== 1'b0) $display("FAIL gate_ack_drop: wr_ack=%b want 0", wr_ack);
        else passes++;
        rd_req  = 1'b1;
        rd_addr = 4'd2;
        exp_q.push_back(8'h37);
        tick();
        rd_req = 1'b0;
        tick();
    endtask

    task automatic test_read_priority();
        px_Y    = 10'd480;
        rd_req  = 1'b1;
        rd_addr = 4'd2;
        wr_req  = 1'b1;
        wr_addr = 4'd2;
        wr_data = 8'h11;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(8'h37);
            tick();
            wr_addr = 4'd5;
            wr_data = 8'hEE;
            checks++;
            if ({rd_valid, wr_busy, wr_ack} !== 3'b110)
                $display("FAIL prio_stall: valid=%b busy=%b ack=%b want 1 1 0 (cycle %0d)",
                         rd_valid, wr_busy, wr_ack, i);
            else passes++;
        end
        rd_req = 1'b0;
        tick();
        checks++;
        if (wr_ack !== 1'b1) $display("FAIL prio_commit: wr_ack=%b want 1", wr_ack);
        else passes++;
        wr_req  = 1'b0;
        rd_req  = 1'b1;
        rd_addr = 4'd2;
        exp_q.push_back(8'h11);
        tick();
        rd_req  = 1'b1;
        rd_addr = 4'd5;
        exp_q.push_back(8'h00);
        tick();
        rd_req = 1'b0;
        tick();
        checks++;
        if ({rd_valid, rd_data} !== {1'b0, 8'h00})
            $display("FAIL prio_hold: valid=%b data=%h want 0 00", rd_valid, rd_data);
        else passes++;
    endtask

    task automatic test_hblank();
        px_X      = 10'd700;
        px_Y      = 10'd100;
        wr_req_h  = 1'b1;
        wr_addr_h = 4'd4;
        wr_data_h = 8'hA5;
        wr_req    = 1'b1;
        wr_addr   = 4'd6;
        wr_data   = 8'h66;
        tick();
        checks++;
        if ({wr_busy_h, wr_ack_h} !== 2'b10)
            $display("FAIL hb_pend: busy=%b ack=%b want 1 0", wr_busy_h, wr_ack_h);
        else passes++;
        tick();
        checks++;
        if (wr_ack_h !== 1'b1) $display("FAIL hb_ack: wr_ack=%b want 1", wr_ack_h);
        else passes++;
        checks++;
        if (wr_busy !== 1'b1) $display("FAIL hb_vonly_blocked: wr_busy=%b want 1", wr_busy);
        else passes++;
        wr_req_h  = 1'b0;
        rd_req_h  = 1'b1;
        rd_addr_h = 4'd4;
        tick();
        rd_req_h = 1'b0;
        checks++;
        if ({rd_valid_h, rd_data_h} !== {1'b1, 8'hA5})
            $display("FAIL hb_read: valid=%b data=%h want 1 a5", rd_valid_h, rd_data_h);
        else passes++;
        px_X = 10'd100;
        px_Y = 10'd480;
        tick();
        checks++;
        if (wr_ack !== 1'b1) $display("FAIL hb_vonly_commit: wr_ack=%b want 1", wr_ack);
        else passes++;
        wr_req = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        px_Y    = 10'd480;
        wr_req  = 1'b1;
        wr_addr = 4'd7;
        wr_data = 8'h77;
        tick();
        tick();
        wr_addr = 4'd7;
        wr_data = 8'h99;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({wr_ack, wr_busy} !== 2'b10)
                $display("FAIL hs_hold: ack=%b busy=%b want 1 0 (cycle %0d)", wr_ack, wr_busy, i);
            else passes++;
            tick();
        end
        wr_req = 1'b0;
        tick();
        checks++;
        if ({wr_ack, wr_busy} !== 2'b00)
            $display("FAIL hs_idle: ack=%b busy=%b want 0 0", wr_ack, wr_busy);
        else passes++;
        wr_req  = 1'b1;
        wr_addr = 4'd8;
        wr_data = 8'h88;
        tick();
        checks++;
        if (wr_busy !== 1'b1) $display("FAIL hs_reaccept: wr_busy=%b want 1", wr_busy);
        else passes++;
        tick();
        wr_req  = 1'b0;
        rd_req  = 1'b1;
        rd_addr = 4'd7;
        exp_q.push_back(8'h77);
        tick();
        rd_addr = 4'd8;
        exp_q.push_back(8'h88);
        tick();
        rd_req = 1'b0;
        tick();
    endtask

    task automatic test_vblank_start();
        int pulses = 0;
        px_Y = 10'd478;
        tick();
        px_Y = 10'd479;
        tick();
        checks++;
        if (vblank_start !== 1'b0) $display("FAIL vbs_early: vblank_start=%b want 0", vblank_start);
        else passes++;
        px_Y = 10'd480;
        tick();
        checks++;
        if (vblank_start !== 1'b1) $display("FAIL vbs_pulse: vblank_start=%b want 1", vblank_start);
        else passes++;
        pulses = 1;
        for (int i = 1; i < 800; i++) begin
            tick();
            if (vblank_start === 1'b1) pulses++;
        end
        px_Y = 10'd481;
        tick();
        if (vblank_start === 1'b1) pulses++;
        px_Y = 10'd0;
        tick();
        if (vblank_start === 1'b1) pulses++;
        tick();
        if (vblank_start === 1'b1) pulses++;
        checks++;
        if (pulses != 1) $display("FAIL vbs_count: pulses=%0d want 1", pulses);
        else passes++;
    endtask

    initial begin
        fork
            forever begin
                @(negedge clk);
                if (!rst && rd_valid === 1'b1) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        $display("FAIL sb_unexpected: rd_valid=1 data=%h with no read outstanding", rd_data);
                    end else begin
                        logic [7:0] e;
                        e = exp_q.pop_front();
                        if (rd_data !== e) $display("FAIL sb_read: rd_data=%h want %h", rd_data, e);
                        else passes++;
                    end
                end
            end
        join_none

        test_reset();
        test_reset_mid_write();
        test_blank_gate();
        test_read_priority();
        test_hblank();
        test_back_to_back();
        test_vblank_start();

        tick();
        checks++;
        if (exp_q.size() != 0) $display("FAIL sb_drain: %0d reads never returned, want 0", exp_q.size());
        else passes++;

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/vga_mem_arbiter.md
# vga_mem_arbiter

Arbiter and scheduler for the shared display register file: a 2^AW x DW single-port store holding the characters and digits drawn on screen. Two requesters share it:
- **Pixel renderer:** reads every cycle it asks, with absolute priority.
- **RTC controller:** writes through a 4-phase req/ack handshake. Writes commit only inside a blanking window derived from the sync generator's `px_X`/`px_Y`, so digits never tear mid-frame.

The block sits between the VGA sync generator, the pixel/text renderer and the RTC bus controller.

## Interface
Parameters:
- `AW`, 4, register-file address width.
- `DW`, 8, data width.
- `HD`, 640, visible pixels per line.
- `VD`, 480, visible lines per frame.
- `VBLANK_ONLY`, 1. When 1, writes commit only during vertical blanking. When 0, they commit during any blanking (horizontal or vertical).

Ports:
- `clk` in 1: system clock.
- `rst` in 1: reset, asynchronous, active-high.
- `px_X` in 10: current column from the sync generator.
- `px_Y` in 10: current row from the sync generator.
- `rd_req` in 1: renderer read request.
- `rd_addr` in AW: read address.
- `rd_data` out DW: read data, registered.
- `rd_valid` out 1: `rd_data` is valid this cycle.
- `wr_req` in 1: RTC write request, a level held until `wr_ack`.
- `wr_addr` in AW: write address, sampled on acceptance.
- `wr_data` in DW: write data, sampled on acceptance.
- `wr_ack` out 1: write committed; held until `wr_req` falls.
- `wr_busy` out 1: a write is latched and awaiting its window.
- `vblank_start` out 1: one-cycle pulse on entry to vertical blanking.

## Operation
- **Window:** `win = (px_Y >= VD)` if `VBLANK_ONLY`, else `win = (px_X >= HD) || (px_Y >= VD)`. `win` is combinational from the current inputs.
- **Reads:**
  - If `rd_req=1` in cycle n, then in cycle n+1: `rd_data = mem[rd_addr]` as sampled at n, and `rd_valid = 1`.
  - `rd_valid=0` otherwise. `rd_data` holds its last value.
  - Reads are never blocked or delayed.
- **Write FSM, IDLE:** `wr_busy=0`, `wr_ack=0`. On `wr_req=1`: latch `wr_addr`/`wr_data` and go to PEND.
- **Write FSM, PEND:** `wr_busy=1`. If `win && !rd_req`, write the latched data to memory and go to ACK. Otherwise stay.
- **Write FSM, ACK:** `wr_ack=1`, `wr_busy=0`. When `wr_req=0`, go to IDLE.
- **Same-cycle read and write:** the read wins and the commit is deferred at least one cycle. There is no read/write forwarding.
  - A read of an address with a pending (uncommitted) write returns the old value.
  - A read issued in the cycle after a commit returns the new value.
- **Request changes after acceptance:** `wr_addr`/`wr_data` changes during PEND are ignored, because the latched copy is used. If `wr_req` drops during PEND, the write still commits and ACK then exits immediately.
- **`vblank_start`:** register `py_d <= px_Y`. Pulse when `px_Y == VD && py_d != VD`. This gives exactly one pulse per frame, even though `px_Y` holds at VD for a full line.
- **Reset:**
  - All memory words, `rd_data`, `rd_valid`, `wr_ack`, `wr_busy`, `vblank_start` and `py_d` go to 0. The FSM goes to IDLE.
  - A pending write is discarded and no ack is issued.
- **Address width:** addresses are exactly AW bits with no out-of-range case. Data is stored unmodified.

## Timing
- Read latency is 1 cycle, with full throughput (a new read every cycle).
- Write acceptance: `wr_req` rises at n, so state is PEND at n+1.
- Earliest commit is at n+1 (memory updated at the n+2 edge). `wr_ack` rises at n+2.
- Worst-case write latency with `VBLANK_ONLY=1` is one frame plus any `rd_req` stall cycles. `rd_req` is low in blanking by renderer contract, so stalls are bounded.
- ACK drop: `wr_req` falls at m, so `wr_ack=0` and the FSM is in IDLE at m+1. The next request is accepted from m+1 onward.
- `vblank_start` is registered: high for the cycle after `px_Y` first equals VD.

## Structure
- **Shared package `vga_pkg`:** HD/VD constants (shared with the sync generator) and the FSM state encoding (IDLE=2'd0, PEND=2'd1, ACK=2'd2).
- **Sub-module `vga_regfile`:** 2^AW x DW single-port store with synchronous write, registered read and async clear on `rst`. It is instantiated once.
- **Top-level logic:** window decode, FSM, write latch and the vblank edge detector.

## Test plan
- **Reset mid-write:** issue `wr_req` (addr 3, data 0x5A) during active video, assert `rst` while in PEND. Required: `wr_ack` never asserts, `mem[3]=0`, `wr_busy=0`.
- **Blanking gate:** `px_Y=100`, `wr_req` (addr 2, data 0x37). Required: `wr_busy` stays 1 and `mem[2]` is unchanged. Step `px_Y` to 480 with `rd_req=0`. Required: commit, `wr_ack=1` one cycle later, then a read of addr 2 returns 0x37.
- **Read priority:** in vblank, hold `rd_req=1` (addr 2) for 3 cycles while a write (addr 2, 0x11) is pending. Required: `rd_valid` every cycle with the old data, commit in the first cycle after `rd_req` drops, and a subsequent read returns 0x11.
- **HBLANK with `VBLANK_ONLY=0`:** set `px_X=700`, `px_Y=100`. Required: write commits, `wr_ack` rises 2 cycles after `wr_req`.
- **4-phase handshake:** hold `wr_req` high 5 cycles after ack. Required: `wr_ack` stays high, no second write occurs, and IDLE is reached 1 cycle after `wr_req` falls.
- **`vblank_start`:** sweep `px_Y` 478 → 479 → 480 (held 800 cycles) → 481 → 0. Required: exactly one `vblank_start` pulse, in the cycle after `px_Y` first reaches 480.
